// File: rtl/navre_io_inport.sv
// ---------------------------------------------------------------------------
// navre_io_inport
//
// IO-mapped inbound byte port for the softusb_navre core. A host-side source
// pushes bytes through a valid/ready handshake into a small FIFO. The CPU
// drains the FIFO and polls status over the navre IO bus.
//
// Register map:
//   ADDR_DATA  read : pop one byte (0x00 and sticky underflow if empty)
//   ADDR_STAT  read : {3'b0, irq_en, eof_seen, underflow, full, nonempty}
//              write: bit0 flush, bit2 clear underflow (W1C), bit4 irq_en
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   in_data/in_valid  host byte and its valid strobe
//   in_ready          FIFO can accept a byte this cycle
//   in_eof            end-of-stream pulse, latched into eof_seen
//   io_re/io_we       navre IO read/write strobes
//   io_a/io_do        navre IO address and write data
//   io_di             registered read data, zero when not addressed
//   irq               level interrupt, irq_en and FIFO nonempty
// ---------------------------------------------------------------------------
module navre_io_inport #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [5:0]  ADDR_DATA  = 6'd43,
  parameter logic [5:0]  ADDR_STAT  = 6'd44
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_eof,
  input  logic       io_re,
  input  logic       io_we,
  input  logic [5:0] io_a,
  input  logic [7:0] io_do,
  output logic [7:0] io_di,
  output logic       irq
);

  localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

  localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic [DEPTH_LOG2:0]   count_next;
  logic                  underflow;
  logic                  eof_seen;
  logic                  irq_en;
  logic [7:0]            io_di_next;

  logic full;
  logic nonempty;
  logic push;
  logic pop;
  logic rd_data;
  logic rd_stat;
  logic wr_stat;
  logic flush;
  logic unused_bits;

  assign full     = (count == CNT_FULL);
  assign nonempty = (count != '0);

  // in_ready depends only on registered count, so a pop in the same cycle
  // never opens a slot for a push while full.
  assign in_ready = !rst && !full;
  assign push     = in_valid && in_ready;

  assign rd_data  = io_re && (io_a == ADDR_DATA);
  assign rd_stat  = io_re && (io_a == ADDR_STAT);
  assign wr_stat  = io_we && (io_a == ADDR_STAT);
  assign pop      = rd_data && nonempty;
  assign flush    = wr_stat && io_do[0];

  assign unused_bits = ^{io_do[7:5], io_do[3], io_do[1]};

  // Occupancy update; flush overrides any push or pop in the same cycle.
  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else if (push && !pop) begin
      count_next = count + CNT_ONE;
    end else if (pop && !push) begin
      count_next = count - CNT_ONE;
    end
  end

  // Read mux. Unaddressed cycles return zero so several IO peripherals can
  // simply OR their io_di outputs together.
  always_comb begin
    io_di_next = 8'h00;
    if (rd_data) begin
      if (nonempty) begin
        io_di_next = mem[rd_ptr];
      end
    end else if (rd_stat) begin
      io_di_next = {3'b000, irq_en, eof_seen, underflow, full, nonempty};
    end
  end

  // Storage is not reset; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Control and status state. Reads see pre-update state because io_di_next
  // is formed from the current registers before any write lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      io_di     <= 8'h00;
      underflow <= 1'b0;
      eof_seen  <= 1'b0;
      irq_en    <= 1'b0;
      irq       <= 1'b0;
    end else begin
      count <= count_next;
      io_di <= io_di_next;

      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
      end

      // A new underflow beats a simultaneous clear.
      if (rd_data && !nonempty) begin
        underflow <= 1'b1;
      end else if (wr_stat && io_do[2]) begin
        underflow <= 1'b0;
      end

      if (flush) begin
        eof_seen <= 1'b0;
      end else if (in_eof) begin
        eof_seen <= 1'b1;
      end

      if (wr_stat) begin
        irq_en <= io_do[4];
      end

      irq <= irq_en && (count_next != '0);
    end
  end

endmodule

// File: tb/tb_navre_io_inport.sv
// ---------------------------------------------------------------------------
// tb_navre_io_inport
//
// Self-checking bench for navre_io_inport. Each cycle is described by a
// vector record holding the inputs to drive and the expected outputs. The
// expected io_di of every cycle is pushed to a scoreboard queue when the
// cycle is driven and popped when the registered result appears.
// ---------------------------------------------------------------------------
module tb_navre_io_inport;

  localparam logic [5:0] A_DATA  = 6'd43;
  localparam logic [5:0] A_STAT  = 6'd44;
  localparam logic [5:0] A_OTHER = 6'd42;

  typedef struct packed {
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       eof;
    logic       re;
    logic       we;
    logic [5:0] a;
    logic [7:0] wdata;
    logic       chk_rdy;
    logic       exp_rdy;
    logic [7:0] exp_di;
    logic       chk_irq;
    logic       exp_irq;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       in_eof;
  logic       io_re;
  logic       io_we;
  logic [5:0] io_a;
  logic [7:0] io_do;
  logic [7:0] io_di;
  logic       irq;

  int tests = 0;
  int fails = 0;
  logic [7:0] sb[$];
  vec_t vecs[$];

  navre_io_inport dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_eof   (in_eof),
    .io_re    (io_re),
    .io_we    (io_we),
    .io_a     (io_a),
    .io_do    (io_do),
    .io_di    (io_di),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t nop();
    vec_t v;
    v = '0;
    return v;
  endfunction

  function automatic vec_t rstv();
    vec_t v;
    v = '0;
    v.rst = 1'b1;
    v.chk_rdy = 1'b1;
    v.exp_rdy = 1'b0;
    return v;
  endfunction

  function automatic vec_t push(input logic [7:0] d);
    vec_t v;
    v = '0;
    v.valid = 1'b1;
    v.data = d;
    v.chk_rdy = 1'b1;
    v.exp_rdy = 1'b1;
    return v;
  endfunction

  function automatic vec_t rdd(input logic [7:0] e);
    vec_t v;
    v = '0;
    v.re = 1'b1;
    v.a = A_DATA;
    v.exp_di = e;
    return v;
  endfunction

  function automatic vec_t rds(input logic [7:0] e);
    vec_t v;
    v = '0;
    v.re = 1'b1;
    v.a = A_STAT;
    v.exp_di = e;
    return v;
  endfunction

  function automatic vec_t wrs(input logic [7:0] w);
    vec_t v;
    v = '0;
    v.we = 1'b1;
    v.a = A_STAT;
    v.wdata = w;
    return v;
  endfunction

  // Drive one cycle's inputs just after a rising edge, check in_ready, and
  // record the io_di expected after the coming edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    rst      = v.rst;
    in_valid = v.valid;
    in_data  = v.data;
    in_eof   = v.eof;
    io_re    = v.re;
    io_we    = v.we;
    io_a     = v.a;
    io_do    = v.wdata;
    #1;
    if (v.chk_rdy) begin
      tests++;
      if (in_ready !== v.exp_rdy) begin
        fails++;
        $display("[TB] FAIL in_ready vec %0d: actual=%b required=%b", idx, in_ready, v.exp_rdy);
      end
    end
    sb.push_back(v.exp_di);
    @(posedge clk);
    #1;
    checkOutput(v, idx);
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    logic [7:0] exp;
    tests++;
    if (sb.size() == 0) begin
      fails++;
      $display("[TB] FAIL scoreboard vec %0d: actual=empty required=entry", idx);
    end else begin
      exp = sb.pop_front();
      if (io_di !== exp) begin
        fails++;
        $display("[TB] FAIL io_di vec %0d: actual=%02h required=%02h", idx, io_di, exp);
      end
    end
    if (v.chk_irq) begin
      tests++;
      if (irq !== v.exp_irq) begin
        fails++;
        $display("[TB] FAIL irq vec %0d: actual=%b required=%b", idx, irq, v.exp_irq);
      end
    end
  endtask

  initial begin
    vec_t v;

    // Reset and basic push/pop/underflow table.
    vecs.push_back(rstv());
    vecs.push_back(rstv());
    v = rds(8'h00); v.chk_rdy = 1'b1; v.exp_rdy = 1'b1; vecs.push_back(v);
    vecs.push_back(push(8'h11));
    vecs.push_back(push(8'h22));
    vecs.push_back(push(8'h33));
    vecs.push_back(rdd(8'h11));
    vecs.push_back(rdd(8'h22));
    vecs.push_back(rdd(8'h33));
    vecs.push_back(rds(8'h00));
    vecs.push_back(rdd(8'h00));
    vecs.push_back(rds(8'h04));
    vecs.push_back(wrs(8'h04));
    vecs.push_back(rds(8'h00));

    // Interrupt enable, one-cycle lag on rise and fall.
    v = wrs(8'h10); v.chk_irq = 1'b1; v.exp_irq = 1'b0; vecs.push_back(v);
    v = push(8'h5A); v.chk_irq = 1'b1; v.exp_irq = 1'b1; vecs.push_back(v);
    v = rdd(8'h5A); v.chk_irq = 1'b1; v.exp_irq = 1'b0; vecs.push_back(v);
    vecs.push_back(rds(8'h10));
    vecs.push_back(wrs(8'h00));

    // End-of-stream flag and flush with a discarded push.
    vecs.push_back(push(8'hC1));
    vecs.push_back(push(8'hC2));
    v = nop(); v.eof = 1'b1; vecs.push_back(v);
    vecs.push_back(rds(8'h09));
    v = wrs(8'h01); v.valid = 1'b1; v.data = 8'h77; v.chk_rdy = 1'b1; v.exp_rdy = 1'b1;
    vecs.push_back(v);
    vecs.push_back(rds(8'h00));
    vecs.push_back(rdd(8'h00));
    vecs.push_back(rds(8'h04));
    vecs.push_back(wrs(8'h04));
    v = wrs(8'h01); v.eof = 1'b1; vecs.push_back(v);
    vecs.push_back(rds(8'h00));

    // Read and write STATUS together: read sees the old irq_en.
    v = rds(8'h00); v.we = 1'b1; v.wdata = 8'h10; vecs.push_back(v);
    vecs.push_back(rds(8'h10));
    vecs.push_back(wrs(8'h00));

    // Push during an empty DATA read is stored, not bypassed.
    v = rdd(8'h00); v.valid = 1'b1; v.data = 8'hAB; v.chk_rdy = 1'b1; v.exp_rdy = 1'b1;
    vecs.push_back(v);
    vecs.push_back(rds(8'h05));
    vecs.push_back(rdd(8'hAB));
    vecs.push_back(wrs(8'h04));
    vecs.push_back(rds(8'h00));

    // Writes to DATA and reads of foreign addresses do nothing.
    vecs.push_back(push(8'h3C));
    v = nop(); v.we = 1'b1; v.a = A_DATA; v.wdata = 8'h01; vecs.push_back(v);
    v = nop(); v.re = 1'b1; v.a = A_OTHER; v.exp_di = 8'h00; vecs.push_back(v);
    vecs.push_back(rdd(8'h3C));
    vecs.push_back(rds(8'h00));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end

    // Fill to full, pop while a push is held off, then drain across the wrap.
    for (int i = 1; i <= 16; i++) begin
      applyStimulus(push(8'(i)), 100 + i);
    end
    v = nop(); v.chk_rdy = 1'b1; v.exp_rdy = 1'b0;
    applyStimulus(v, 200);
    applyStimulus(rds(8'h03), 201);
    v = rdd(8'h01); v.valid = 1'b1; v.data = 8'h99; v.chk_rdy = 1'b1; v.exp_rdy = 1'b0;
    applyStimulus(v, 202);
    applyStimulus(push(8'h99), 203);
    v = nop(); v.chk_rdy = 1'b1; v.exp_rdy = 1'b0;
    applyStimulus(v, 204);
    for (int i = 2; i <= 16; i++) begin
      applyStimulus(rdd(8'(i)), 300 + i);
    end
    applyStimulus(rdd(8'h99), 317);
    applyStimulus(rds(8'h00), 318);

    // Reset mid-stream discards contents and clears irq.
    applyStimulus(wrs(8'h10), 400);
    v = push(8'hE1); v.chk_irq = 1'b1; v.exp_irq = 1'b1;
    applyStimulus(v, 401);
    applyStimulus(push(8'hE2), 402);
    v = rstv(); v.valid = 1'b1; v.data = 8'hE3; v.chk_irq = 1'b1; v.exp_irq = 1'b0;
    applyStimulus(v, 403);
    v = rds(8'h00); v.chk_rdy = 1'b1; v.exp_rdy = 1'b1;
    applyStimulus(v, 404);
    applyStimulus(rdd(8'h00), 405);
    applyStimulus(rds(8'h04), 406);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
